// File: rtl/axi_mem_if_pkg.sv
// ---------------------------------------------------------------------------
// axi_mem_if_pkg
//   Shared types for the AXI write responder and its address generator.
//   burst_t    : AXI burst encoding (FIXED / INCR / WRAP / reserved)
//   wr_state_t : write-responder FSM states
//   RESP_*     : B channel response codes
//   wrap_len_ok: legal WRAP burst lengths (2, 4, 8 or 16 beats)
// ---------------------------------------------------------------------------
package axi_mem_if_pkg;

   typedef enum logic [1:0] {
      BURST_FIXED = 2'b00,
      BURST_INCR  = 2'b01,
      BURST_WRAP  = 2'b10,
      BURST_RSVD  = 2'b11
   } burst_t;

   typedef enum logic [1:0] {
      WR_IDLE,
      WR_WRITE,
      WR_RESP
   } wr_state_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   function automatic logic wrap_len_ok(input logic [7:0] len);
      return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
   endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// ---------------------------------------------------------------------------
// axi_burst_addr_gen
//   Combinational AXI next-beat address calculation.
//   addr_i      : current beat byte address
//   len_i       : burst length - 1
//   size_i      : log2 bytes per beat
//   burst_i     : burst type
//   next_addr_o : address of the following beat (carries out of the top bit dropped)
//   wrap_err_o  : WRAP requested with an illegal length; address falls back to INCR
// ---------------------------------------------------------------------------
module axi_burst_addr_gen
   import axi_mem_if_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 32
) (
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [7:0]            len_i,
   input  logic [2:0]            size_i,
   input  burst_t                burst_i,
   output logic [ADDR_WIDTH-1:0] next_addr_o,
   output logic                  wrap_err_o
);

   logic [ADDR_WIDTH-1:0] inc;
   logic [ADDR_WIDTH-1:0] incr_addr;
   logic [ADDR_WIDTH-1:0] wrap_mask;

   always_comb begin
      inc         = ADDR_WIDTH'(1) << size_i;
      incr_addr   = addr_i + inc;
      // Wrap window is the total burst size in bytes.
      wrap_mask   = ((ADDR_WIDTH'(len_i) + ADDR_WIDTH'(1)) << size_i) - ADDR_WIDTH'(1);
      next_addr_o = incr_addr;
      wrap_err_o  = 1'b0;
      case (burst_i)
         BURST_FIXED: next_addr_o = addr_i;
         BURST_WRAP: begin
            if (wrap_len_ok(len_i)) begin
               next_addr_o = (addr_i & ~wrap_mask) | (incr_addr & wrap_mask);
            end else begin
               next_addr_o = incr_addr;
               wrap_err_o  = 1'b1;
            end
         end
         default: next_addr_o = incr_addr;
      endcase
   end

endmodule

// File: rtl/axi_write_ctrl.sv
// ---------------------------------------------------------------------------
// axi_write_ctrl
//   AXI4 write-channel responder, one outstanding burst. Accepts an AW burst,
//   turns every W beat into one memory write at the computed beat address and
//   returns a single B response per burst.
//   clk_i, rst_ni              : clock, asynchronous active-low reset
//   aw_*                       : AW channel (valid/ready, addr, len, size, burst, id, user)
//   w_*                        : W channel (valid/ready, data, strb, last)
//   b_*                        : B channel (valid/ready, resp, id, user)
//   mem_req_o/mem_we_o         : memory write request / write enable
//   mem_addr_o/wdata_o/be_o    : beat address, data and byte enables
//   mem_gnt_i                  : memory grant, a write completes on req & gnt
// ---------------------------------------------------------------------------
module axi_write_ctrl
   import axi_mem_if_pkg::*;
#(
   parameter int unsigned ID_WIDTH   = 4,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned USER_WIDTH = 6
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    aw_valid_i,
   input  logic [ADDR_WIDTH-1:0]   aw_addr_i,
   input  logic [7:0]              aw_len_i,
   input  logic [2:0]              aw_size_i,
   input  logic [1:0]              aw_burst_i,
   input  logic [ID_WIDTH-1:0]     aw_id_i,
   input  logic [USER_WIDTH-1:0]   aw_user_i,
   output logic                    aw_ready_o,
   input  logic                    w_valid_i,
   input  logic [DATA_WIDTH-1:0]   w_data_i,
   input  logic [DATA_WIDTH/8-1:0] w_strb_i,
   input  logic                    w_last_i,
   output logic                    w_ready_o,
   output logic                    b_valid_o,
   output logic [1:0]              b_resp_o,
   output logic [ID_WIDTH-1:0]     b_id_o,
   output logic [USER_WIDTH-1:0]   b_user_o,
   input  logic                    b_ready_i,
   output logic                    mem_req_o,
   output logic                    mem_we_o,
   output logic [ADDR_WIDTH-1:0]   mem_addr_o,
   output logic [DATA_WIDTH-1:0]   mem_wdata_o,
   output logic [DATA_WIDTH/8-1:0] mem_be_o,
   input  logic                    mem_gnt_i
);

   localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
   localparam logic [2:0]  MAX_SIZE   = 3'($clog2(STRB_WIDTH));

   wr_state_t             state_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [7:0]            len_q;
   logic [2:0]            size_q;
   burst_t                burst_q;
   logic [ID_WIDTH-1:0]   id_q;
   logic [USER_WIDTH-1:0] user_q;
   logic [7:0]            beat_cnt_q;
   logic                  err_q;

   logic [ADDR_WIDTH-1:0] next_addr;
   logic                  wrap_err;
   logic                  in_write;
   logic                  in_resp;
   logic                  beat_fire;
   logic                  last_beat;
   logic                  last_mismatch;
   logic                  aw_cfg_err;

   axi_burst_addr_gen #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_addr_gen (
      .addr_i      (addr_q),
      .len_i       (len_q),
      .size_i      (size_q),
      .burst_i     (burst_q),
      .next_addr_o (next_addr),
      .wrap_err_o  (wrap_err)
   );

   assign in_write      = (state_q == WR_WRITE);
   assign in_resp       = (state_q == WR_RESP);
   assign beat_fire     = in_write && w_valid_i && mem_gnt_i;
   assign last_beat     = (beat_cnt_q == len_q);
   assign last_mismatch = (w_last_i != last_beat);
   assign aw_cfg_err    = (aw_burst_i == 2'b11) || (aw_size_i > MAX_SIZE);

   // Beat count, not w_last_i, ends the burst; a misplaced last only flags SLVERR.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= WR_IDLE;
         addr_q     <= '0;
         len_q      <= '0;
         size_q     <= '0;
         burst_q    <= BURST_FIXED;
         id_q       <= '0;
         user_q     <= '0;
         beat_cnt_q <= '0;
         err_q      <= 1'b0;
      end else begin
         case (state_q)
            WR_IDLE: begin
               if (aw_valid_i) begin
                  addr_q     <= aw_addr_i;
                  len_q      <= aw_len_i;
                  size_q     <= aw_size_i;
                  burst_q    <= burst_t'(aw_burst_i);
                  id_q       <= aw_id_i;
                  user_q     <= aw_user_i;
                  beat_cnt_q <= '0;
                  err_q      <= aw_cfg_err;
                  state_q    <= WR_WRITE;
               end
            end
            WR_WRITE: begin
               if (beat_fire) begin
                  addr_q     <= next_addr;
                  beat_cnt_q <= beat_cnt_q + 8'd1;
                  err_q      <= err_q | wrap_err | last_mismatch;
                  if (last_beat) begin
                     state_q <= WR_RESP;
                  end
               end
            end
            WR_RESP: begin
               if (b_ready_i) begin
                  state_q <= WR_IDLE;
               end
            end
            default: state_q <= WR_IDLE;
         endcase
      end
   end

   always_comb begin
      aw_ready_o  = (state_q == WR_IDLE);
      w_ready_o   = in_write && mem_gnt_i;
      mem_req_o   = in_write && w_valid_i;
      mem_we_o    = in_write && w_valid_i;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      mem_be_o    = '0;
      b_valid_o   = in_resp;
      b_resp_o    = RESP_OKAY;
      b_id_o      = '0;
      b_user_o    = '0;
      if (in_write) begin
         mem_addr_o  = addr_q;
         mem_wdata_o = w_data_i;
         mem_be_o    = w_strb_i;
      end
      if (in_resp) begin
         b_resp_o = err_q ? RESP_SLVERR : RESP_OKAY;
         b_id_o   = id_q;
         b_user_o = user_q;
      end
   end

endmodule

// File: tb/tb_axi_write_ctrl.sv
// ---------------------------------------------------------------------------
// tb_axi_write_ctrl
//   Self-checking bench for axi_write_ctrl: directed bursts plus randomized
//   bursts, compared every cycle against a transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_axi_write_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        aw_valid;
   logic [31:0] aw_addr;
   logic [7:0]  aw_len;
   logic [2:0]  aw_size;
   logic [1:0]  aw_burst;
   logic [3:0]  aw_id;
   logic [5:0]  aw_user;
   logic        aw_ready;
   logic        w_valid;
   logic [63:0] w_data;
   logic [7:0]  w_strb;
   logic        w_last;
   logic        w_ready;
   logic        b_valid;
   logic [1:0]  b_resp;
   logic [3:0]  b_id;
   logic [5:0]  b_user;
   logic        b_ready;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [63:0] mem_wdata;
   logic [7:0]  mem_be;
   logic        mem_gnt;

   always #5 clk = ~clk;

   axi_write_ctrl #(
      .ID_WIDTH   (4),
      .ADDR_WIDTH (32),
      .DATA_WIDTH (64),
      .USER_WIDTH (6)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .aw_valid_i  (aw_valid),
      .aw_addr_i   (aw_addr),
      .aw_len_i    (aw_len),
      .aw_size_i   (aw_size),
      .aw_burst_i  (aw_burst),
      .aw_id_i     (aw_id),
      .aw_user_i   (aw_user),
      .aw_ready_o  (aw_ready),
      .w_valid_i   (w_valid),
      .w_data_i    (w_data),
      .w_strb_i    (w_strb),
      .w_last_i    (w_last),
      .w_ready_o   (w_ready),
      .b_valid_o   (b_valid),
      .b_resp_o    (b_resp),
      .b_id_o      (b_id),
      .b_user_o    (b_user),
      .b_ready_i   (b_ready),
      .mem_req_o   (mem_req),
      .mem_we_o    (mem_we),
      .mem_addr_o  (mem_addr),
      .mem_wdata_o (mem_wdata),
      .mem_be_o    (mem_be),
      .mem_gnt_i   (mem_gnt)
   );

   typedef struct {
      logic [31:0] addr;
      logic [63:0] data;
      logic [7:0]  strb;
   } beat_t;

   typedef struct {
      logic [1:0] resp;
      logic [3:0] id;
      logic [5:0] user;
   } bresp_t;

   beat_t       exp_beats[$];
   bresp_t      exp_b[$];
   logic [31:0] obs_addr[$];
   logic [1:0]  obs_resp;
   logic [3:0]  obs_id;
   int          checks = 0;
   int          errors = 0;
   int          beats_left = 0;
   bit          resp_pending = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s wait bound expired at %0t", name, $time);
   endtask

   // Address of beat i from the burst rules, in closed form.
   function automatic logic [31:0] beat_addr(input logic [31:0] start, input int len,
                                             input int size, input logic [1:0] burst, input int i);
      logic [31:0] step;
      logic [31:0] span;
      step = (32'd1 << size) * 32'(i);
      if (burst == 2'b00) return start;
      if (burst == 2'b10 && (len inside {1, 3, 7, 15})) begin
         span = 32'(len + 1) << size;
         return (start & ~(span - 32'd1)) | ((start + step) & (span - 32'd1));
      end
      return start + step;
   endfunction

   // Reference model + compare, evaluated on the falling edge. Inputs are stable
   // from 1ns after a rising edge to the next rising edge, so what is seen here
   // is exactly what the DUT samples on the coming edge.
   always @(negedge clk) begin : cmp
      bit in_w;
      bit in_r;
      if (!rst_n) begin
         beats_left   = 0;
         resp_pending = 1'b0;
         exp_beats.delete();
         exp_b.delete();
         chk("rst_aw_ready", 64'(aw_ready), 64'd1);
         chk("rst_w_ready",  64'(w_ready),  64'd0);
         chk("rst_b_valid",  64'(b_valid),  64'd0);
         chk("rst_b_resp",   64'(b_resp),   64'd0);
         chk("rst_b_id",     64'(b_id),     64'd0);
         chk("rst_b_user",   64'(b_user),   64'd0);
         chk("rst_mem_req",  64'(mem_req),  64'd0);
         chk("rst_mem_we",   64'(mem_we),   64'd0);
         chk("rst_mem_addr", 64'(mem_addr), 64'd0);
         chk("rst_mem_wdata", mem_wdata,    64'd0);
         chk("rst_mem_be",   64'(mem_be),   64'd0);
      end else begin
         in_w = (beats_left > 0);
         in_r = resp_pending && (beats_left == 0);
         chk("aw_ready", 64'(aw_ready), 64'(!(in_w || in_r)));
         chk("w_ready",  64'(w_ready),  64'(in_w && mem_gnt));
         chk("mem_req",  64'(mem_req),  64'(in_w && w_valid));
         chk("mem_we",   64'(mem_we),   64'(in_w && w_valid));
         chk("b_valid",  64'(b_valid),  64'(in_r));
         if (in_w && w_valid && exp_beats.size() > 0) begin
            chk("mem_addr",  64'(mem_addr), 64'(exp_beats[0].addr));
            chk("mem_wdata", mem_wdata,     exp_beats[0].data);
            chk("mem_be",    64'(mem_be),   64'(exp_beats[0].strb));
         end
         if (in_r && exp_b.size() > 0) begin
            chk("b_resp", 64'(b_resp), 64'(exp_b[0].resp));
            chk("b_id",   64'(b_id),   64'(exp_b[0].id));
            chk("b_user", 64'(b_user), 64'(exp_b[0].user));
         end
         if (in_w && w_valid && mem_gnt) begin
            obs_addr.push_back(mem_addr);
            if (exp_beats.size() > 0) void'(exp_beats.pop_front());
            beats_left--;
         end else if (in_r && b_ready) begin
            obs_resp = b_resp;
            obs_id   = b_id;
            if (exp_b.size() > 0) void'(exp_b.pop_front());
            resp_pending = 1'b0;
         end else if (!in_w && !in_r && aw_valid) begin
            beats_left   = int'(aw_len) + 1;
            resp_pending = 1'b1;
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // One burst: flip = beat whose w_last is inverted (-1 none); stalls of -1 are
   // random; abort_after >= 0 resets the DUT once that beat has completed.
   task automatic do_burst(input logic [31:0] addr, input int len, input int size,
                           input logic [1:0] burst, input logic [3:0] id, input logic [5:0] user,
                           input int flip, input int gnt_stall, input int bready_stall,
                           input int abort_after);
      logic   err;
      beat_t  bt;
      bresp_t br;
      int     waited;
      int     stall;
      logic [63:0] data[256];
      logic [7:0]  strb[256];
      err = (burst == 2'b11) || (size > 3) ||
            (burst == 2'b10 && !(len inside {1, 3, 7, 15})) ||
            (flip >= 0 && flip <= len);
      obs_addr.delete();
      for (int i = 0; i <= len; i++) begin
         data[i] = {$urandom, $urandom};
         strb[i] = 8'($urandom);
         bt.addr = beat_addr(addr, len, size, burst, i);
         bt.data = data[i];
         bt.strb = strb[i];
         exp_beats.push_back(bt);
      end
      br.resp = err ? 2'b10 : 2'b00;
      br.id   = id;
      br.user = user;
      exp_b.push_back(br);

      aw_valid = 1'b1;
      aw_addr  = addr;
      aw_len   = 8'(len);
      aw_size  = 3'(size);
      aw_burst = burst;
      aw_id    = id;
      aw_user  = user;
      w_valid  = 1'($urandom);
      waited   = 0;
      while (1) begin
         @(negedge clk);
         if (aw_ready) break;
         waited++;
         if (waited > 50) begin
            timeout("aw_handshake");
            aw_valid = 1'b0;
            return;
         end
      end
      cyc();
      aw_valid = 1'b0;
      aw_addr  = $urandom;
      aw_len   = 8'($urandom);
      aw_id    = 4'($urandom);

      for (int i = 0; i <= len; i++) begin
         if (abort_after >= 0 && i == abort_after + 1) begin
            rst_n   = 1'b0;
            w_valid = 1'b0;
            mem_gnt = 1'b0;
            cyc();
            rst_n = 1'b1;
            @(negedge clk);
            chk("post_rst_aw_ready", 64'(aw_ready), 64'd1);
            chk("post_rst_b_valid",  64'(b_valid),  64'd0);
            cyc();
            return;
         end
         if (i > 0) begin
            w_valid = 1'b0;
            mem_gnt = 1'($urandom);
            repeat ($urandom_range(0, 1)) cyc();
         end
         w_valid = 1'b1;
         w_data  = data[i];
         w_strb  = strb[i];
         w_last  = (i == len) ^ (i == flip);
         stall   = (gnt_stall < 0) ? int'($urandom_range(0, 2)) : gnt_stall;
         mem_gnt = 1'b0;
         repeat (stall) cyc();
         mem_gnt = 1'b1;
         waited  = 0;
         while (1) begin
            @(negedge clk);
            if (w_ready) break;
            waited++;
            if (waited > 20) begin
               timeout("w_handshake");
               w_valid = 1'b0;
               return;
            end
         end
         cyc();
      end

      w_last  = 1'($urandom);
      mem_gnt = 1'($urandom);
      w_valid = 1'($urandom);
      b_ready = 1'b0;
      stall   = (bready_stall < 0) ? int'($urandom_range(0, 3)) : bready_stall;
      repeat (stall) cyc();
      b_ready = 1'b1;
      waited  = 0;
      while (1) begin
         @(negedge clk);
         if (b_valid) break;
         waited++;
         if (waited > 50) begin
            timeout("b_handshake");
            b_ready = 1'b0;
            return;
         end
      end
      cyc();
      b_ready = 1'b0;
      w_valid = 1'b0;
   endtask

   task automatic pin_addrs(input string name, input int n, input logic [31:0] a0,
                            input logic [31:0] a1, input logic [31:0] a2, input logic [31:0] a3);
      logic [31:0] lit[4];
      lit = '{a0, a1, a2, a3};
      chk({name, "_count"}, 64'(obs_addr.size()), 64'(n));
      for (int i = 0; i < n; i++) begin
         if (i < obs_addr.size()) chk({name, "_addr"}, 64'(obs_addr[i]), 64'(lit[i]));
      end
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog simulation time limit reached");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   initial begin : stim
      rst_n    = 1'b0;
      aw_valid = 1'b0;
      aw_addr  = '0;
      aw_len   = '0;
      aw_size  = '0;
      aw_burst = '0;
      aw_id    = '0;
      aw_user  = '0;
      w_valid  = 1'b0;
      w_data   = 64'hDEAD_BEEF_0123_4567;
      w_strb   = 8'hA5;
      w_last   = 1'b0;
      b_ready  = 1'b0;
      mem_gnt  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc();

      // INCR id 5, 0x100, 4 beats of 8 bytes
      do_burst(32'h100, 3, 3, 2'b01, 4'd5, 6'd17, -1, -1, -1, -1);
      pin_addrs("incr", 4, 32'h100, 32'h108, 32'h110, 32'h118);
      chk("incr_b_resp", 64'(obs_resp), 64'd0);
      chk("incr_b_id",   64'(obs_id),   64'd5);

      // WRAP 0x38, 4 beats of 4 bytes
      do_burst(32'h38, 3, 2, 2'b10, 4'd2, 6'd3, -1, -1, -1, -1);
      pin_addrs("wrap", 4, 32'h38, 32'h3C, 32'h30, 32'h34);
      chk("wrap_b_resp", 64'(obs_resp), 64'd0);

      // FIXED 0x40, 3 beats
      do_burst(32'h40, 2, 3, 2'b00, 4'd7, 6'd1, -1, -1, -1, -1);
      pin_addrs("fixed", 3, 32'h40, 32'h40, 32'h40, 32'h0);

      // early w_last on beat 1: all 4 beats still written, SLVERR
      do_burst(32'h1000, 3, 3, 2'b01, 4'd3, 6'd9, 1, -1, -1, -1);
      pin_addrs("early_last", 4, 32'h1000, 32'h1008, 32'h1010, 32'h1018);
      chk("early_last_b_resp", 64'(obs_resp), 64'd2);

      // grant low 3 cycles per beat, b_ready low 5 cycles
      do_burst(32'h2000, 3, 3, 2'b01, 4'd11, 6'd33, -1, 3, 5, -1);
      pin_addrs("stall", 4, 32'h2000, 32'h2008, 32'h2010, 32'h2018);
      chk("stall_b_id", 64'(obs_id), 64'd11);

      // reset after beat 2 of an 8-beat burst, then a fresh burst
      do_burst(32'h200, 7, 3, 2'b01, 4'd4, 6'd4, -1, -1, -1, 2);
      do_burst(32'h300, 1, 3, 2'b01, 4'd9, 6'd2, -1, -1, -1, -1);
      pin_addrs("post_rst", 2, 32'h300, 32'h308, 32'h0, 32'h0);
      chk("post_rst_b_resp", 64'(obs_resp), 64'd0);
      chk("post_rst_b_id",   64'(obs_id),   64'd9);

      // address carry out of bit 31 is dropped
      do_burst(32'hFFFF_FFF8, 1, 3, 2'b01, 4'd1, 6'd1, -1, -1, -1, -1);
      pin_addrs("carry", 2, 32'hFFFF_FFF8, 32'h0, 32'h0, 32'h0);

      for (int n = 0; n < 40; n++) begin
         int          sel;
         int          len;
         int          size;
         int          flip;
         logic [1:0]  bu;
         logic [31:0] addr;
         sel = $urandom_range(0, 9);
         bu  = (sel < 2) ? 2'b00 : (sel < 6) ? 2'b01 : (sel < 9) ? 2'b10 : 2'b11;
         if (bu == 2'b10 && $urandom_range(0, 3) != 0) begin
            sel = $urandom_range(0, 3);
            len = (sel == 0) ? 1 : (sel == 1) ? 3 : (sel == 2) ? 7 : 15;
         end else begin
            len = $urandom_range(0, 15);
         end
         size = ($urandom_range(0, 7) == 0) ? int'($urandom_range(4, 7)) : int'($urandom_range(0, 3));
         flip = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, len)) : -1;
         addr = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FF00 | 32'($urandom_range(0, 255))) : $urandom;
         do_burst(addr, len, size, bu, 4'($urandom), 6'($urandom), flip, -1, -1, -1);
      end

      repeat (3) cyc();
      chk("beats_drained", 64'(exp_beats.size()), 64'd0);
      chk("b_drained",     64'(exp_b.size()),     64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
